// File: rtl/masked_hpc3_mul_chain_pkg.sv
// Shared constants and index helpers for the masked HPC3 multiplier chain.
// Pairs of shares (i,j) with i<j map to a flat quadratic-randomness index.
package masked_hpc3_mul_chain_pkg;

    function automatic int num_quad(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // Cycles from the in_valid cycle until stage k presents its result.
    function automatic int chain_latency(input int k);
        return k + 1;
    endfunction

    // Which in_r slot feeds stage k.
    function automatic int r_idx(input int k, input int reuse);
        return (reuse != 0) ? 0 : k;
    endfunction

    // Symmetric pair index: (i,j) and (j,i) share the same r/p slot.
    function automatic int pair_idx(input int i, input int j, input int n);
        int lo;
        int hi;
        int q;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        q  = 0;
        for (int x = 0; x < lo; x++) begin
            q += n - 1 - x;
        end
        return q + hi - lo - 1;
    endfunction

endpackage

// File: rtl/masked_hpc3_mul_chain_if.sv
// Operand/result bundle of the masked multiplier chain.
// in_valid qualifies in_a/in_b/in_r for one cycle; there is no ready, the chain
// accepts every cycle. out_valid[k] qualifies out_x[k]; out_busy = any in flight.
interface masked_hpc3_mul_chain_if #(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 1,
    parameter int NUM_STAGES = 2
);
    localparam int NQ = masked_hpc3_mul_chain_pkg::num_quad(NUM_SHARES);

    logic                                                in_valid;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                in_a;
    logic [NUM_STAGES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] in_b;
    logic [NUM_STAGES-1:0][NQ-1:0][BIT_WIDTH-1:0]         in_r;
    logic [NUM_STAGES-1:0][NQ-1:0][BIT_WIDTH-1:0]         in_p;
    logic [NUM_STAGES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] out_x;
    logic [NUM_STAGES-1:0]                               out_valid;
    logic                                                out_busy;

    modport master (
        output in_valid, in_a, in_b, in_r, in_p,
        input  out_x, out_valid, out_busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_r, in_p,
        output out_x, out_valid, out_busy
    );
endinterface

// File: rtl/masked_hpc3_1_mul.sv
// First-order-style HPC3 masked AND with one register stage, any share count.
// Every cross term is registered before recombination so shares never meet unmasked.
module masked_hpc3_1_mul
    import masked_hpc3_mul_chain_pkg::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 1,
    localparam int NQ        = num_quad(NUM_SHARES)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] a,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] b,
    input  logic [NQ-1:0][BIT_WIDTH-1:0]         r,
    input  logic [NQ-1:0][BIT_WIDTH-1:0]         p,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] c
);

    // Diagonal of term_m holds a_i*b_i; off-diagonal pairs carry the blinded products.
    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] term_m;
    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] term_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            term_m <= '0;
            term_p <= '0;
        end else begin
            for (int i = 0; i < NUM_SHARES; i++) begin
                for (int j = 0; j < NUM_SHARES; j++) begin
                    if (i == j) begin
                        term_m[i][j] <= a[i] & b[i];
                        term_p[i][j] <= '0;
                    end else begin
                        term_m[i][j] <= a[i] & (b[j] ^ r[pair_idx(i, j, NUM_SHARES)]);
                        term_p[i][j] <= (~a[i] & r[pair_idx(i, j, NUM_SHARES)])
                                        ^ p[pair_idx(i, j, NUM_SHARES)];
                    end
                end
            end
        end
    end

    always_comb begin
        c = '0;
        for (int i = 0; i < NUM_SHARES; i++) begin
            for (int j = 0; j < NUM_SHARES; j++) begin
                c[i] = c[i] ^ term_m[i][j] ^ term_p[i][j];
            end
        end
    end

endmodule

// File: rtl/masked_hpc3_1_mul_skewed.sv
// HPC3 multiplier whose b and r operands are delayed DELAY_BR cycles so they
// line up with an a operand arriving late from an upstream stage.
module masked_hpc3_1_mul_skewed
    import masked_hpc3_mul_chain_pkg::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 1,
    parameter int DELAY_BR   = 1,
    localparam int NQ        = num_quad(NUM_SHARES)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] a,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] b,
    input  logic [NQ-1:0][BIT_WIDTH-1:0]         r,
    input  logic [NQ-1:0][BIT_WIDTH-1:0]         p,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] c
);

    logic [DELAY_BR-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] b_dly;
    logic [DELAY_BR-1:0][NQ-1:0][BIT_WIDTH-1:0]         r_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            b_dly <= '0;
            r_dly <= '0;
        end else begin
            b_dly[0] <= b;
            r_dly[0] <= r;
            for (int d = 1; d < DELAY_BR; d++) begin
                b_dly[d] <= b_dly[d-1];
                r_dly[d] <= r_dly[d-1];
            end
        end
    end

    // p is deliberately not delayed: the caller supplies it in the compute cycle.
    masked_hpc3_1_mul #(
        .NUM_SHARES (NUM_SHARES),
        .BIT_WIDTH  (BIT_WIDTH)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b_dly[DELAY_BR-1]),
        .r   (r_dly[DELAY_BR-1]),
        .p   (p),
        .c   (c)
    );

endmodule

// File: rtl/masked_valid_chain.sv
// Valid shift register for fixed-latency masked pipelines, plus a busy flag
// covering both the in-flight slots and the operation being offered now.
module masked_valid_chain #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    output logic [DEPTH-1:0] stage_valid,
    output logic             busy
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
        end else begin
            stage_valid[0] <= valid;
            for (int d = 1; d < DEPTH; d++) begin
                stage_valid[d] <= stage_valid[d-1];
            end
        end
    end

    assign busy = (|stage_valid) | valid;

endmodule

// File: rtl/masked_hpc3_mul_chain.sv
// Chain of HPC3 masked multipliers: x(k+1) = x(k) AND b(k), x(0) = a.
// All operands enter together; stage k realigns its b/r internally by k cycles.
module masked_hpc3_mul_chain
    import masked_hpc3_mul_chain_pkg::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 1,
    parameter int NUM_STAGES = 2,
    parameter int REUSE_R    = 1
) (
    input  logic                     in_clock,
    input  logic                     in_reset,
    masked_hpc3_mul_chain_if.slave   bus
);

    logic [NUM_STAGES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] x;
    logic [NUM_STAGES-1:0]                               stage_valid;
    logic                                                busy;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int RI = r_idx(k, REUSE_R);
        if (k == 0) begin : g_head
            masked_hpc3_1_mul #(
                .NUM_SHARES (NUM_SHARES),
                .BIT_WIDTH  (BIT_WIDTH)
            ) u_mul (
                .clk (in_clock),
                .rst (in_reset),
                .a   (bus.in_a),
                .b   (bus.in_b[0]),
                .r   (bus.in_r[0]),
                .p   (bus.in_p[0]),
                .c   (x[0])
            );
        end else begin : g_tail
            masked_hpc3_1_mul_skewed #(
                .NUM_SHARES (NUM_SHARES),
                .BIT_WIDTH  (BIT_WIDTH),
                .DELAY_BR   (chain_latency(k) - 1)
            ) u_mul (
                .clk (in_clock),
                .rst (in_reset),
                .a   (x[k-1]),
                .b   (bus.in_b[k]),
                .r   (bus.in_r[RI]),
                .p   (bus.in_p[k]),
                .c   (x[k])
            );
        end
    end

    masked_valid_chain #(
        .DEPTH (NUM_STAGES)
    ) u_valid (
        .clk         (in_clock),
        .rst         (in_reset),
        .valid       (bus.in_valid),
        .stage_valid (stage_valid),
        .busy        (busy)
    );

    assign bus.out_x     = x;
    assign bus.out_valid = stage_valid;
    assign bus.out_busy  = busy;

endmodule

// File: tb/tb_masked_hpc3_mul_chain.sv
// Bench for the masked HPC3 chain: three instances (shared r, fresh r, and a
// single-stage three-share variant) driven in lockstep from one directed sequence.
module tb_masked_hpc3_mul_chain;

    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    masked_hpc3_mul_chain_if #(.NUM_SHARES(2), .BIT_WIDTH(8), .NUM_STAGES(3)) bus_r1 ();
    masked_hpc3_mul_chain_if #(.NUM_SHARES(2), .BIT_WIDTH(8), .NUM_STAGES(3)) bus_r0 ();
    masked_hpc3_mul_chain_if #(.NUM_SHARES(3), .BIT_WIDTH(1), .NUM_STAGES(1)) bus_d ();

    masked_hpc3_mul_chain #(.NUM_SHARES(2), .BIT_WIDTH(8), .NUM_STAGES(3), .REUSE_R(1)) u_dut_r1 (
        .in_clock (clk), .in_reset (rst), .bus (bus_r1.slave));
    masked_hpc3_mul_chain #(.NUM_SHARES(2), .BIT_WIDTH(8), .NUM_STAGES(3), .REUSE_R(0)) u_dut_r0 (
        .in_clock (clk), .in_reset (rst), .bus (bus_r0.slave));
    masked_hpc3_mul_chain #(.NUM_SHARES(3), .BIT_WIDTH(1), .NUM_STAGES(1), .REUSE_R(1)) u_dut_d (
        .in_clock (clk), .in_reset (rst), .bus (bus_d.slave));

    // Reference history: what was offered and whether reset was high, per cycle.
    bit         issued [MAXC];
    bit         rst_h  [MAXC];
    logic [7:0] a_h    [MAXC];
    logic [7:0] b_h    [MAXC][3];
    bit         da_h   [MAXC];
    bit         db_h   [MAXC];
    int         cyc;
    int         n_cmp;
    int         n_fail;
    int         stream_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [1:0][7:0] share2(input logic [7:0] v);
        logic [7:0] m;
        m = 8'($urandom);
        return {v ^ m, m};
    endfunction

    function automatic logic [2:0] share3(input bit v);
        logic [1:0] m;
        m = 2'($urandom_range(0, 3));
        return {v ^ m[1] ^ m[0], m[1], m[0]};
    endfunction

    // An op issued at cycle t is visible at cycle c unless reset was high at any cycle t..c-1.
    function automatic bit exp_valid(input int t, input int c);
        if (t < 0) return 1'b0;
        if (!issued[t]) return 1'b0;
        for (int u = t; u < c; u++) begin
            if (rst_h[u]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_chain(input string name, input logic [2:0][1:0][7:0] ox,
                               input logic [2:0] ov, input logic ob);
        bit         ev;
        bit         any;
        int         t;
        logic [7:0] ex;
        any = 1'b0;
        for (int k = 0; k < 3; k++) begin
            t  = cyc - k - 1;
            ev = exp_valid(t, cyc);
            any |= ev;
            chk($sformatf("%s_valid%0d", name, k), 64'(ov[k]), 64'(ev));
            if (ev) begin
                ex = a_h[t];
                for (int j = 0; j <= k; j++) ex &= b_h[t][j];
                chk($sformatf("%s_x%0d", name, k), 64'(ox[k][1] ^ ox[k][0]), 64'(ex));
            end
            if (rst_h[cyc-1]) begin
                chk($sformatf("%s_x%0d_reset", name, k), 64'(ox[k]), 64'd0);
            end
        end
        chk($sformatf("%s_busy", name), 64'(ob), 64'(any | issued[cyc-1]));
    endtask

    task automatic check_all();
        bit ev;
        check_chain("r1", bus_r1.out_x, bus_r1.out_valid, bus_r1.out_busy);
        check_chain("r0", bus_r0.out_x, bus_r0.out_valid, bus_r0.out_busy);
        if (bus_r1.out_valid[2] === 1'b1) stream_cnt++;
        ev = exp_valid(cyc - 1, cyc);
        chk("deg_valid", 64'(bus_d.out_valid), 64'(ev));
        if (ev) chk("deg_x", 64'(^bus_d.out_x[0]), 64'(da_h[cyc-1] & db_h[cyc-1]));
        if (rst_h[cyc-1]) chk("deg_x_reset", 64'(bus_d.out_x), 64'd0);
        chk("deg_busy", 64'(bus_d.out_busy), 64'(ev | issued[cyc-1]));
    endtask

    // One clock: drive all instances, advance, then compare against the history.
    task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b0,
                        input logic [7:0] b1, input logic [7:0] b2, input bit r,
                        input bit zr, input bit da, input bit db);
        logic [2:0][0:0][7:0] rr;
        issued[cyc]  = v;
        rst_h[cyc]   = r;
        a_h[cyc]     = a;
        b_h[cyc][0]  = b0;
        b_h[cyc][1]  = b1;
        b_h[cyc][2]  = b2;
        da_h[cyc]    = da;
        db_h[cyc]    = db;

        rst = r;
        bus_r1.in_valid = v;
        bus_r1.in_a     = share2(a);
        bus_r1.in_b[0]  = share2(b0);
        bus_r1.in_b[1]  = share2(b1);
        bus_r1.in_b[2]  = share2(b2);
        rr = 24'($urandom);
        if (zr) begin
            rr[1] = '0;
            rr[2] = '0;
        end
        bus_r1.in_r     = rr;
        bus_r1.in_p     = 24'($urandom);

        bus_r0.in_valid = v;
        bus_r0.in_a     = share2(a);
        bus_r0.in_b[0]  = share2(b0);
        bus_r0.in_b[1]  = share2(b1);
        bus_r0.in_b[2]  = share2(b2);
        rr = 24'($urandom);
        if (zr) begin
            rr[1] = '0;
            rr[2] = '0;
        end
        bus_r0.in_r     = rr;
        bus_r0.in_p     = 24'($urandom);

        bus_d.in_valid  = v;
        bus_d.in_a      = share3(da);
        bus_d.in_b      = share3(db);
        bus_d.in_r      = 3'($urandom_range(0, 7));
        bus_d.in_p      = 3'($urandom_range(0, 7));

        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'b0, 1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        cyc        = 0;
        stream_cnt = 0;

        // Reset held three cycles with in_valid high: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'b1, 1'b0, 1'($urandom), 1'($urandom));
        end
        idle(1);

        // Directed product: 0xF3 & 0x5A = 0x52, & 0xCC = 0x40, & 0x0F = 0x00.
        step(1'b1, 8'hF3, 8'h5A, 8'hCC, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(4);

        // Sixteen back-to-back all-ones operations.
        stream_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
        end
        idle(4);
        chk("stream_len", 64'(stream_cnt), 64'd16);

        // Random traffic, first with r[1..2] held at zero, then randomised.
        for (int i = 0; i < 12; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 1'b0, 1'b1, 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 12; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 1'b0, 1'b0, 1'($urandom), 1'($urandom));
        end
        idle(4);

        // Reset one cycle after issue: the operation must vanish.
        step(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Exhaustive single-bit AND on the three-share single-stage instance.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'b0, 1'b0, 1'(i >> 1), 1'(i & 1));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
